// File: rtl/scale_cache_reader.sv
// Scale cache reader: walks a w x h frame in raster order, issues one scale-cache
// read per pixel and streams the returned pixels out through a 2-entry FIFO.
module scale_cache_reader #(
  parameter int COORD_BITS = 10,
  parameter int DATA_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [COORD_BITS-1:0] frame_w,
  input  logic [COORD_BITS-1:0] frame_h,
  output logic                  ready,
  output logic                  done,
  output logic [COORD_BITS-1:0] scr_raddrX,
  output logic [COORD_BITS-1:0] scr_raddrY,
  output logic                  scr_re,
  input  logic [DATA_BITS-1:0]  scr_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_BITS-1:0]  out_data,
  output logic [COORD_BITS-1:0] out_x,
  output logic [COORD_BITS-1:0] out_y,
  output logic                  out_eol,
  output logic                  out_eof
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                state, state_nxt;
  logic [COORD_BITS-1:0] w_lat, h_lat, rx, ry;
  logic                  done_q, start_frame, zero_frame, frame_end;

  logic                  issue_p0, last_x_p0, last_y_p0;
  logic                  vld_p1, eol_p1, eof_p1;
  logic [COORD_BITS-1:0] x_p1, y_p1;

  logic [DATA_BITS-1:0]  fifo_data [2];
  logic [COORD_BITS-1:0] fifo_x [2];
  logic [COORD_BITS-1:0] fifo_y [2];
  logic                  fifo_eol [2];
  logic                  fifo_eof [2];
  logic                  wr_ptr, rd_ptr, push, pop;
  logic [1:0]            count;
  logic [2:0]            credit;

  // Stage p0: read issue. Credit counts the slot freed by a pop this cycle so
  // that one read per cycle is sustained with out_ready held high.
  assign last_x_p0 = (rx == w_lat - COORD_BITS'(1));
  assign last_y_p0 = (ry == h_lat - COORD_BITS'(1));
  assign push      = vld_p1;
  assign pop       = (count != 2'd0) && out_ready;
  assign credit    = {1'b0, count} + {2'b0, vld_p1} - {2'b0, pop};
  assign issue_p0  = (state == S_RUN) && (credit < 3'd2);

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    zero_frame  = 1'b0;
    frame_end   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (frame_w == '0 || frame_h == '0) begin
            zero_frame = 1'b1;
          end else begin
            start_frame = 1'b1;
            state_nxt   = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (issue_p0 && last_x_p0 && last_y_p0) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && fifo_eof[rd_ptr]) begin
          frame_end = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_lat  <= '0;
      h_lat  <= '0;
      rx     <= '0;
      ry     <= '0;
      done_q <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      done_q <= zero_frame || frame_end;
      vld_p1 <= issue_p0;
      if (start_frame) begin
        w_lat <= frame_w;
        h_lat <= frame_h;
        rx    <= '0;
        ry    <= '0;
      end else if (issue_p0) begin
        if (last_x_p0) begin
          rx <= '0;
          ry <= ry + COORD_BITS'(1);
        end else begin
          rx <= rx + COORD_BITS'(1);
        end
      end
    end
  end

  // Stage p1: tags travel with the read while the cache produces scr_q.
  always_ff @(posedge clk) begin
    if (issue_p0) begin
      x_p1   <= rx;
      y_p1   <= ry;
      eol_p1 <= last_x_p0;
      eof_p1 <= last_x_p0 && last_y_p0;
    end
  end

  // Stage p2: FIFO capture at the end of the return cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= scr_q;
      fifo_x[wr_ptr]    <= x_p1;
      fifo_y[wr_ptr]    <= y_p1;
      fifo_eol[wr_ptr]  <= eol_p1;
      fifo_eof[wr_ptr]  <= eof_p1;
    end
  end

  assign ready      = (state == S_IDLE);
  assign done       = done_q;
  assign scr_re     = issue_p0;
  assign scr_raddrX = issue_p0 ? rx : '0;
  assign scr_raddrY = issue_p0 ? ry : '0;

  // Payload is forced to zero when empty so unreset storage never shows.
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_x     = out_valid ? fifo_x[rd_ptr]    : '0;
  assign out_y     = out_valid ? fifo_y[rd_ptr]    : '0;
  assign out_eol   = out_valid && fifo_eol[rd_ptr];
  assign out_eof   = out_valid && fifo_eof[rd_ptr];

endmodule

// File: tb/tb_scale_cache_reader.sv
// Bench for scale_cache_reader: table of frames plus hand-written reset and
// held-start sequences, with a pixel scoreboard and a FIFO occupancy model.
module tb_scale_cache_reader;

  logic       clk = 1'b0;
  logic       resetn, start, ready, done, scr_re, out_valid, out_ready;
  logic       out_eol, out_eof;
  logic [9:0] frame_w, frame_h, scr_raddrX, scr_raddrY, out_x, out_y;
  logic [7:0] scr_q, out_data;

  scale_cache_reader #(.COORD_BITS(10), .DATA_BITS(8)) dut (
    .clk(clk), .resetn(resetn), .start(start), .frame_w(frame_w), .frame_h(frame_h),
    .ready(ready), .done(done), .scr_raddrX(scr_raddrX), .scr_raddrY(scr_raddrY),
    .scr_re(scr_re), .scr_q(scr_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_eol(out_eol), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  // Scale cache model: pixel value x + 16*y, one cycle read latency.
  always @(posedge clk)
    scr_q <= scr_re ? 8'(scr_raddrX + 16 * scr_raddrY) : 8'hEE;

  typedef struct {
    int w; int h; int mode; int exp_beats; int exp_lat; bit consec;
  } vec_t;

  int nvec = 0, nerr = 0, cyc = 0;
  logic [29:0] expq [$];
  bit   mon_en = 0;
  int   occ = 0, infl = 0, ix = 0, iy = 0, tw = 1;
  int   beats, first_valid_cyc, first_beat_cyc, last_beat_cyc, done_cnt, done_cyc;
  int   re_cnt, nready_cnt;
  bit   stall_prev = 0;
  logic [29:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    beats = 0; first_valid_cyc = -1; first_beat_cyc = -1; last_beat_cyc = -1;
    done_cnt = 0; done_cyc = -1; re_cnt = 0; nready_cnt = 0;
  endtask

  task automatic push_frame(input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        expq.push_back({8'(x + 16 * y), 10'(x), 10'(y), (x == w - 1), (x == w - 1) && (y == h - 1)});
  endtask

  // Monitor: scoreboard, stall stability, issue order and occupancy model.
  always @(negedge clk) begin
    logic [29:0] cur, e;
    int pop;
    if (mon_en) begin
      cur = {out_data, out_x, out_y, out_eol, out_eof};
      pop = (out_valid && out_ready) ? 1 : 0;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (scr_re) re_cnt++;
      if (!ready) nready_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      check("valid_vs_occupancy", out_valid, occ != 0);
      if (scr_re) begin
        check("issue_credit", (occ + infl - pop) < 2, 1);
        check("read_addr", {scr_raddrX, scr_raddrY}, {10'(ix), 10'(iy)});
        if (ix == tw - 1) begin ix = 0; iy++; end else ix++;
      end else begin
        check("idle_addr", {scr_raddrX, scr_raddrY}, 20'd0);
      end
      if (stall_prev) check("stall_hold", {out_valid, cur}, {1'b1, held});
      if (pop != 0) begin
        check("beat_expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check("beat", cur, e);
        end
        beats++;
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
      end
      stall_prev = resetn && out_valid && !out_ready;
      held = cur;
      occ  = resetn ? occ + infl - pop : 0;
      infl = (resetn && scr_re) ? 1 : 0;
    end
  end

  task automatic set_ready(input int mode);
    case (mode)
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  endtask

  task automatic run_frame(input vec_t v);
    int t, start_cyc;
    t = 0;
    while (!ready && t < 200) begin @(posedge clk); #1; t++; end
    check("ready_before_start", ready, 1);
    clear_stats();
    tw = v.w; ix = 0; iy = 0;
    if (v.exp_beats != 0) push_frame(v.w, v.h);
    start = 1'b1; frame_w = 10'(v.w); frame_h = 10'(v.h); out_ready = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; frame_w = 10'($urandom); frame_h = 10'($urandom);
    t = 0;
    while (done_cnt == 0 && t < 400) begin set_ready(v.mode); @(posedge clk); #1; t++; end
    check("done_seen", done_cnt > 0, 1);
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("beat_count", beats, v.exp_beats);
    check("done_count", done_cnt, 1);
    check("queue_drained", expq.size(), 0);
    if (v.exp_beats != 0) begin
      check("done_after_last_beat", done_cyc - last_beat_cyc, 1);
      check("first_valid_latency", first_valid_cyc - start_cyc, v.exp_lat);
    end else begin
      check("zero_done_latency", done_cyc - start_cyc, 1);
      check("zero_no_valid", first_valid_cyc < 0, 1);
      check("zero_no_reads", re_cnt, 0);
      check("zero_ready_held", nready_cnt, 0);
    end
    if (v.consec) check("consecutive_beats", last_beat_cyc - first_beat_cyc, v.exp_beats - 1);
    expq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_scr"}, {scr_re, scr_raddrX, scr_raddrY}, 21'd0);
    check({tag, "_out"}, {out_valid, out_data, out_x, out_y, out_eol, out_eof}, 31'd0);
  endtask

  vec_t vecs [7];

  initial begin
    int t;
    vecs[0] = '{4, 2, 0, 8, 3, 1};
    vecs[1] = '{3, 3, 1, 9, 3, 0};
    vecs[2] = '{1, 1, 0, 1, 3, 1};
    vecs[3] = '{0, 5, 0, 0, 0, 0};
    vecs[4] = '{5, 0, 0, 0, 0, 0};
    vecs[5] = '{2, 3, 2, 6, 3, 0};
    vecs[6] = '{7, 1, 0, 7, 3, 1};

    resetn = 1'b0; start = 1'b0; out_ready = 1'b0; frame_w = '0; frame_h = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    mon_en = 1; resetn = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("after_reset");

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Reset in the middle of a 4x4 frame, then a clean 2x2 frame.
    clear_stats();
    tw = 4; ix = 0; iy = 0;
    push_frame(4, 4);
    start = 1'b1; frame_w = 10'd4; frame_h = 10'd4; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (beats < 5 && t < 100) begin @(posedge clk); #1; t++; end
    check("midframe_beats", beats, 5);
    resetn = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midframe_reset");
    expq.delete();
    resetn = 1'b1;
    run_frame('{2, 2, 0, 4, 3, 1});

    // start held through a 3x2 frame; the next frame begins only at ready.
    clear_stats();
    tw = 3; ix = 0; iy = 0;
    push_frame(3, 2);
    start = 1'b1; frame_w = 10'd3; frame_h = 10'd2; out_ready = 1'b1;
    @(posedge clk); #1;
    frame_w = 10'd2; frame_h = 10'd1;
    t = 0;
    while (!done && t < 200) begin @(posedge clk); #1; t++; end
    check("hold_first_done", done, 1);
    check("hold_first_beats", beats, 6);
    check("hold_ready_at_done", ready, 1);
    push_frame(2, 1);
    tw = 2; ix = 0; iy = 0;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (done_cnt < 2 && t < 200) begin @(posedge clk); #1; t++; end
    repeat (3) begin @(posedge clk); #1; end
    check("hold_total_beats", beats, 8);
    check("hold_done_count", done_cnt, 2);
    check("hold_queue_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
